// File: rtl/pipeline_fetch_if.sv
// Instruction-memory fetch bus: req/ready request phase, rvalid/rdata response phase.
// master = fetch stage, slave = instruction memory.
interface pipeline_fetch_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ready_i,
    input  imem_rvalid_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ready_i,
    output imem_rvalid_i,
    output imem_rdata_i
  );
endinterface

// File: rtl/pipeline_fetch.sv
// IF stage: owns the fetch PC, issues one outstanding instruction-memory request at a time,
// presents {pc, pc+4, instruction, valid} to IF/ID and absorbs a response arriving under a
// decode stall in a one-entry skid register. Execute-stage redirects flush held/in-flight fetches.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (flags redirects to non-word-aligned targets
// on misalign_o); when undefined misalign_o is tied low and no extra state exists.
module pipeline_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             pc_select_i,
  input  logic [31:0]      pc_new_i,
  input  logic             stall_i,
  pipeline_fetch_if.master imem,
  output logic [31:0]      pc_o,
  output logic [31:0]      pcsrc_o,
  output logic [31:0]      instruction_o,
  output logic             valid_o,
  output logic             misalign_o
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            kill_q, kill_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic [XLEN-1:0] skid_instr_q, skid_instr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pcsrc_q, pcsrc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            valid_q, valid_d;

  logic            accept_c;
  logic            hold_ifid_c;
  logic [XLEN-1:0] fetch_pc_inc_c;
  logic [XLEN-1:0] skid_pc_inc_c;
  logic [XLEN-1:0] target_c;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic mis_q, mis_d;
  logic mis_pend_q, mis_pend_d;
  logic skid_mis_q, skid_mis_d;
`endif

  // Next-state, fetch PC, skid and IF/ID update; redirect overrides everything but reset.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    kill_d       = kill_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    pc_d         = pc_q;
    pcsrc_d      = pcsrc_q;
    instr_d      = instr_q;
    valid_d      = valid_q;
`ifdef FETCH_MISALIGN_CHECK_EN
    mis_d        = mis_q;
    mis_pend_d   = mis_pend_q;
    skid_mis_d   = skid_mis_q;
`endif

    accept_c       = (state_q == S_REQ) && imem.imem_ready_i;
    hold_ifid_c    = valid_q && stall_i;
    fetch_pc_inc_c = fetch_pc_q + XLEN'(4);
    skid_pc_inc_c  = skid_pc_q + XLEN'(4);
    target_c       = pc_new_i & ~XLEN'(3);

    // IF/ID drains to a bubble unless decode is holding a valid entry.
    if (!hold_ifid_c) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end

    case (state_q)
      S_REQ: begin
        if (accept_c) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem.imem_rvalid_i) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else if (!hold_ifid_c) begin
            pc_d       = fetch_pc_q;
            pcsrc_d    = fetch_pc_inc_c;
            instr_d    = imem.imem_rdata_i;
            valid_d    = 1'b1;
            fetch_pc_d = fetch_pc_inc_c;
            state_d    = S_REQ;
`ifdef FETCH_MISALIGN_CHECK_EN
            mis_d      = mis_pend_q;
            mis_pend_d = 1'b0;
            if (mis_pend_q) instr_d = NOP_INSTR;
`endif
          end else begin
            skid_pc_d    = fetch_pc_q;
            skid_instr_d = imem.imem_rdata_i;
            fetch_pc_d   = fetch_pc_inc_c;
            state_d      = S_HOLD;
`ifdef FETCH_MISALIGN_CHECK_EN
            skid_mis_d   = mis_pend_q;
            mis_pend_d   = 1'b0;
`endif
          end
        end
      end
      S_HOLD: begin
        if (!stall_i) begin
          pc_d    = skid_pc_q;
          pcsrc_d = skid_pc_inc_c;
          instr_d = skid_instr_q;
          valid_d = 1'b1;
          state_d = S_REQ;
`ifdef FETCH_MISALIGN_CHECK_EN
          mis_d   = skid_mis_q;
          if (skid_mis_q) instr_d = NOP_INSTR;
`endif
        end
      end
      default: state_d = S_REQ;
    endcase

    // Redirect: retarget, flush IF/ID and skid; an already accepted request is killed.
    if (pc_select_i) begin
      fetch_pc_d = target_c;
      pc_d       = pc_q;
      pcsrc_d    = pcsrc_q;
      valid_d    = 1'b0;
      instr_d    = NOP_INSTR;
      case (state_q)
        S_REQ: begin
          state_d = accept_c ? S_WAIT : S_REQ;
          kill_d  = accept_c;
        end
        S_WAIT: begin
          state_d = imem.imem_rvalid_i ? S_REQ : S_WAIT;
          kill_d  = !imem.imem_rvalid_i;
        end
        default: begin
          state_d = S_REQ;
          kill_d  = 1'b0;
        end
      endcase
`ifdef FETCH_MISALIGN_CHECK_EN
      mis_d      = |pc_new_i[1:0];
      mis_pend_d = |pc_new_i[1:0];
      skid_mis_d = 1'b0;
`endif
    end
  end

  // State, fetch PC, skid and IF/ID registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q      <= S_REQ;
      fetch_pc_q   <= RESET_PC;
      kill_q       <= 1'b0;
      skid_pc_q    <= '0;
      skid_instr_q <= NOP_INSTR;
      pc_q         <= RESET_PC;
      pcsrc_q      <= RESET_PC + XLEN'(4);
      instr_q      <= NOP_INSTR;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      kill_q       <= kill_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      pc_q         <= pc_d;
      pcsrc_q      <= pcsrc_d;
      instr_q      <= instr_d;
      valid_q      <= valid_d;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  // Misalignment flag, its pending marker for the next load, and the skid copy.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      mis_q      <= 1'b0;
      mis_pend_q <= 1'b0;
      skid_mis_q <= 1'b0;
    end else begin
      mis_q      <= mis_d;
      mis_pend_q <= mis_pend_d;
      skid_mis_q <= skid_mis_d;
    end
  end

  assign misalign_o = mis_q;
`else
  assign misalign_o = 1'b0;
`endif

  // Request is only asserted out of reset in the request state.
  assign imem.imem_req_o  = reset_i && (state_q == S_REQ);
  assign imem.imem_addr_o = fetch_pc_q;

  assign pc_o          = pc_q;
  assign pcsrc_o       = pcsrc_q;
  assign instruction_o = instr_q;
  assign valid_o       = valid_q;

endmodule

// File: tb/tb_pipeline_fetch.sv
// Bench for pipeline_fetch: randomized memory/stall/redirect/reset traffic against a
// program-order scoreboard (after reset or a redirect to T, decode must see T, T+4, ...
// each carrying mem_word(pc)), plus directed timing checks.
module tb_pipeline_fetch;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        pc_select_i;
  logic [31:0] pc_new_i;
  logic        stall_i;
  logic [31:0] pc_o, pcsrc_o, instruction_o;
  logic        valid_o, misalign_o;

  pipeline_fetch_if bus ();

  pipeline_fetch #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .pc_select_i   (pc_select_i),
    .pc_new_i      (pc_new_i),
    .stall_i       (stall_i),
    .imem          (bus),
    .pc_o          (pc_o),
    .pcsrc_o       (pcsrc_o),
    .instruction_o (instruction_o),
    .valid_o       (valid_o),
    .misalign_o    (misalign_o)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] next_push_pc;
  int          cons_cyc[$];
  logic [31:0] cons_pc[$];

  // Memory behaviour knobs.
  int mem_lat_fixed = 0;
  int mem_lat_max   = 0;
  int ready_pct     = 100;
  bit spurious_en   = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out (cycle %0d)", name, cycle);
  endtask

  // Program order from a new target; a misaligned target's first entry is flagged when enabled.
  function automatic void expect_stream(input logic [31:0] target);
    exp_t e;
    logic [31:0] p;
    p = target & ~32'h3;
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      e.pc    = p;
      e.instr = mem_word(p);
      e.mis   = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      if (i == 0 && target[1:0] != 2'b00) begin
        e.instr = NOP_INSTR;
        e.mis   = 1'b1;
      end
`endif
      exp_q.push_back(e);
      p = p + 32'd4;
    end
    next_push_pc = p;
  endfunction

  function automatic void extend_stream();
    exp_t e;
    while (exp_q.size() < 16) begin
      e.pc    = next_push_pc;
      e.instr = mem_word(next_push_pc);
      e.mis   = 1'b0;
      exp_q.push_back(e);
      next_push_pc = next_push_pc + 32'd4;
    end
  endfunction

  // Monitor: consumption = valid_o && !stall_i; then apply reset/redirect to the model.
  logic prev_rst_low  = 1'b0;
  logic prev_redirect = 1'b0;
  exp_t mon_e;
  always begin
    @(negedge clk);
    if (prev_rst_low) begin
      check("reset_pc", pc_o, RESET_PC);
      check("reset_pcsrc", pcsrc_o, RESET_PC + 32'd4);
      check("reset_instr", instruction_o, NOP_INSTR);
      check("reset_valid", 32'(valid_o), 32'd0);
      check("reset_misalign", 32'(misalign_o), 32'd0);
    end else if (prev_redirect) begin
      check("redirect_valid", 32'(valid_o), 32'd0);
      check("redirect_instr", instruction_o, NOP_INSTR);
    end
    if (reset_i === 1'b0) check("req_in_reset", 32'(bus.imem_req_o), 32'd0);
    if (bus.imem_req_o === 1'b1) check("addr_align", 32'(bus.imem_addr_o[1:0]), 32'd0);
    if (valid_o === 1'b1 && stall_i === 1'b0) begin
      if (exp_q.size() == 0) begin
        fail_timeout("scoreboard_empty");
      end else begin
        mon_e = exp_q.pop_front();
        check("entry_pc", pc_o, mon_e.pc);
        check("entry_pcsrc", pcsrc_o, mon_e.pc + 32'd4);
        check("entry_instr", instruction_o, mon_e.instr);
        check("entry_misalign", 32'(misalign_o), 32'(mon_e.mis));
        cons_cyc.push_back(cycle);
        cons_pc.push_back(pc_o);
        extend_stream();
      end
    end
    if (reset_i === 1'b0) expect_stream(RESET_PC);
    else if (pc_select_i === 1'b1) expect_stream(pc_new_i);
    prev_rst_low  = (reset_i === 1'b0);
    prev_redirect = (pc_select_i === 1'b1) && (reset_i === 1'b1);
  end

  // Instruction memory: one response per accepted request after a latency; a request
  // outstanding across reset is delivered late as garbage; optional stray rvalids when idle.
  bit          mem_out = 1'b0;
  bit          late_pending = 1'b0;
  logic [31:0] mem_addr;
  int          mem_lat;
  initial begin
    logic        acc;
    logic [31:0] a;
    logic        rst_seen;
    bus.imem_ready_i  = 1'b0;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = 32'h0;
    forever begin
      @(negedge clk);
      acc      = (bus.imem_req_o === 1'b1) && (bus.imem_ready_i === 1'b1);
      a        = bus.imem_addr_o;
      rst_seen = (reset_i === 1'b0);
      @(posedge clk);
      #1;
      if (rst_seen) begin
        if (mem_out) late_pending = 1'b1;
        mem_out = 1'b0;
      end else if (acc) begin
        mem_out  = 1'b1;
        mem_addr = a;
        mem_lat  = (mem_lat_fixed >= 0) ? mem_lat_fixed : int'($urandom_range(mem_lat_max, 0));
      end
      bus.imem_rvalid_i = 1'b0;
      bus.imem_rdata_i  = $urandom;
      if (late_pending) begin
        bus.imem_rvalid_i = 1'b1;
        bus.imem_rdata_i  = 32'hDEAD_BEEF;
        late_pending      = 1'b0;
      end else if (mem_out) begin
        if (mem_lat == 0) begin
          bus.imem_rvalid_i = 1'b1;
          bus.imem_rdata_i  = mem_word(mem_addr);
          mem_out           = 1'b0;
        end else begin
          mem_lat--;
        end
      end else if (spurious_en && $urandom_range(99, 0) < 5) begin
        bus.imem_rvalid_i = 1'b1;
        bus.imem_rdata_i  = 32'hBAD0_0000 | 32'($urandom_range(255, 0));
      end
      bus.imem_ready_i = ($urandom_range(99, 0) < 32'(ready_pct));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      #1;
      if (bus.imem_req_o === 1'b1 && bus.imem_ready_i === 1'b1) found = 1'b1;
    end
    if (!found) fail_timeout(name);
  endtask

  task automatic wait_cons_pc(input string name, input logic [31:0] pc, input int bound);
    bit found;
    found = 1'b0;
    for (int i = 0; i < bound && !found; i++) begin
      @(negedge clk);
      #1;
      if (cons_pc.size() > 0 && cons_pc[cons_pc.size()-1] == pc) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s: entry pc %h never consumed within %0d cycles", name, pc, bound);
    end
  endtask

  task automatic wait_req_addr(input string name, input logic [31:0] addr, input int bound);
    bit found;
    found = 1'b0;
    for (int i = 0; i < bound && !found; i++) begin
      @(negedge clk);
      #1;
      if (bus.imem_req_o === 1'b1) begin
        check(name, bus.imem_addr_o, addr);
        found = 1'b1;
      end else begin
        check({name, "_valid_low"}, 32'(valid_o), 32'd0);
      end
    end
    if (!found) fail_timeout(name);
  endtask

  initial begin
    int base, n0, redir_cyc, rnd_base;
    logic [31:0] t;

    reset_i     = 1'b0;
    pc_select_i = 1'b0;
    pc_new_i    = 32'h0;
    stall_i     = 1'b0;
    repeat (3) tick();
    reset_i = 1'b1;

    // Back-to-back fetch: 0, 4, 8 one instruction every 2 cycles.
    base = cons_pc.size();
    for (int i = 0; i < 40 && cons_pc.size() < base + 3; i++) begin
      @(negedge clk);
      #1;
    end
    if (cons_pc.size() < base + 3) fail_timeout("first_three");
    else begin
      check("first_pc0", cons_pc[base], 32'h0);
      check("first_pc2", cons_pc[base+2], 32'h8);
      check("issue_gap01", 32'(cons_cyc[base+1] - cons_cyc[base]), 32'd2);
      check("issue_gap12", 32'(cons_cyc[base+2] - cons_cyc[base+1]), 32'd2);
    end

    // Stall long enough to park a response in the skid, then release.
    tick();
    stall_i = 1'b1;
    repeat (6) tick();
    @(negedge clk);
    #1;
    check("hold_no_req", 32'(bus.imem_req_o), 32'd0);
    tick();
    stall_i = 1'b0;
    n0 = cons_pc.size();
    @(negedge clk);
    #1;
    @(negedge clk);
    #1;
    if (cons_pc.size() != n0 + 2) fail_timeout("skid_release");
    else begin
      check("skid_next_cycle", 32'(cons_cyc[n0+1] - cons_cyc[n0]), 32'd1);
      check("skid_seq", cons_pc[n0+1], cons_pc[n0] + 32'd4);
      check("skid_next_req", bus.imem_addr_o, cons_pc[n0+1] + 32'd4);
    end

    // Redirect while waiting; the late response must be dropped.
    mem_lat_fixed = 2;
    wait_acc("acc_before_kill");
    tick();
    pc_select_i = 1'b1;
    pc_new_i    = 32'h0000_0100;
    tick();
    pc_select_i = 1'b0;
    wait_req_addr("kill_next_req", 32'h0000_0100, 20);
    wait_cons_pc("kill_target", 32'h0000_0100, 30);

    // Redirect in the same cycle as the response: no kill left behind.
    mem_lat_fixed = 1;
    wait_acc("acc_before_same");
    tick();
    tick();
    pc_select_i = 1'b1;
    pc_new_i    = 32'h0000_0240;
    redir_cyc   = cycle;
    tick();
    pc_select_i = 1'b0;
    @(negedge clk);
    #1;
    check("same_req", 32'(bus.imem_req_o), 32'd1);
    check("same_addr", bus.imem_addr_o, 32'h0000_0240);
    wait_cons_pc("same_target", 32'h0000_0240, 20);
    if (cons_pc.size() > 0) check("same_latency", 32'(cons_cyc[cons_cyc.size()-1] - redir_cyc), 32'd4);

    // Address wrap at the top of memory.
    mem_lat_fixed = 0;
    tick();
    pc_select_i = 1'b1;
    pc_new_i    = 32'hFFFF_FFF8;
    tick();
    pc_select_i = 1'b0;
    wait_cons_pc("wrap_top", 32'hFFFF_FFFC, 30);
    wait_cons_pc("wrap_zero", 32'h0000_0000, 30);

    // Misaligned target.
    tick();
    pc_select_i = 1'b1;
    pc_new_i    = 32'h0000_0102;
    tick();
    pc_select_i = 1'b0;
    @(negedge clk);
    #1;
`ifdef FETCH_MISALIGN_CHECK_EN
    check("misalign_flag", 32'(misalign_o), 32'd1);
`else
    check("misalign_flag", 32'(misalign_o), 32'd0);
`endif
    check("misalign_addr", bus.imem_addr_o, 32'h0000_0100);
    wait_cons_pc("misalign_target", 32'h0000_0100, 30);

    // Reset during a wait with stall and redirect also asserted; the late rvalid is ignored.
    mem_lat_fixed = 3;
    wait_acc("acc_before_reset");
    tick();
    reset_i     = 1'b0;
    stall_i     = 1'b1;
    pc_select_i = 1'b1;
    pc_new_i    = 32'h0000_0500;
    tick();
    reset_i     = 1'b1;
    stall_i     = 1'b0;
    pc_select_i = 1'b0;
    wait_cons_pc("reset_refetch", RESET_PC, 30);

    // Randomized traffic.
    mem_lat_fixed = -1;
    mem_lat_max   = 2;
    ready_pct     = 70;
    spurious_en   = 1'b1;
    rnd_base      = cons_pc.size();
    for (int c = 0; c < 3000; c++) begin
      tick();
      stall_i     = ($urandom_range(99, 0) < 30);
      pc_select_i = ($urandom_range(99, 0) < 4);
      case ($urandom_range(3, 0))
        0:       t = $urandom;
        1:       t = 32'hFFFF_FFF0 | 32'($urandom_range(15, 0));
        2:       t = 32'($urandom_range(255, 0));
        default: t = 32'h0000_1000 + 32'($urandom_range(63, 0));
      endcase
      pc_new_i = t;
      reset_i  = !($urandom_range(999, 0) < 3);
    end
    tick();
    stall_i     = 1'b0;
    pc_select_i = 1'b0;
    reset_i     = 1'b1;
    repeat (10) tick();
    checks++;
    if (cons_pc.size() - rnd_base < 200) begin
      errors++;
      $display("FAIL random_progress: got %0d entries required at least 200", cons_pc.size() - rnd_base);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
